// File: rtl/acc_pkg.sv
// Shared types for the accumulator unit: opcodes, sequencer FSM states and the flag bundle.
package acc_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_SHR  = 3'b110,
        OP_MUL  = 3'b111
    } op_t;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_RUN
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/acc_alu.sv
// Combinational single-cycle ALU for acc_unit: produces result and N/Z/C/V from acc and operand.
module acc_alu
    import acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  op_t              op_i,
    output logic [WIDTH-1:0] res_o,
    output flags_t           flags_o
);

    logic [WIDTH:0] wide;

    always_comb begin
        wide      = '0;
        res_o     = acc_i;
        flags_o.c = 1'b0;
        flags_o.v = 1'b0;
        case (op_i)
            OP_LOAD: res_o = opnd_i;
            OP_ADD: begin
                wide      = {1'b0, acc_i} + {1'b0, opnd_i};
                res_o     = wide[WIDTH-1:0];
                flags_o.c = wide[WIDTH];
                flags_o.v = (acc_i[WIDTH-1] == opnd_i[WIDTH-1]) && (res_o[WIDTH-1] != acc_i[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                wide      = {1'b0, acc_i} - {1'b0, opnd_i};
                res_o     = wide[WIDTH-1:0];
                flags_o.c = wide[WIDTH];
                flags_o.v = (acc_i[WIDTH-1] != opnd_i[WIDTH-1]) && (res_o[WIDTH-1] != acc_i[WIDTH-1]);
            end
            OP_AND: res_o = acc_i & opnd_i;
            OP_OR:  res_o = acc_i | opnd_i;
            OP_SHR: begin
                res_o     = {1'b0, acc_i[WIDTH-1:1]};
                flags_o.c = acc_i[0];
            end
            default: res_o = acc_i;
        endcase
        flags_o.n = res_o[WIDTH-1];
        flags_o.z = (res_o == '0);
    end

endmodule

// File: rtl/acc_unit.sv
// Accumulator with extension register, source mux, single-cycle ALU ops and a
// WIDTH-cycle unsigned shift-add multiply driven by a start/busy/done handshake.
module acc_unit
    import acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NSRC  = 3,
    parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSRC*WIDTH-1:0] src_i,
    input  logic [SELW-1:0]       src_sel,
    input  logic [2:0]            op,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      acc_o,
    output logic [WIDTH-1:0]      ext_o,
    output logic                  n,
    output logic                  z,
    output logic                  c,
    output logic                  v
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  ext_q, ext_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    flags_t            flags_q, flags_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  operand;
    logic [WIDTH-1:0]  alu_res;
    flags_t            alu_flags;
    logic [WIDTH:0]    mul_sum;

    // Out-of-range selects fall back to bus 0.
    always_comb begin
        operand = src_i[WIDTH-1:0];
        for (int unsigned j = 0; j < NSRC; j++) begin
            if (src_sel == SELW'(j)) operand = src_i[j*WIDTH +: WIDTH];
        end
    end

    acc_alu #(.WIDTH(WIDTH)) u_alu (
        .acc_i   (acc_q),
        .opnd_i  (operand),
        .op_i    (op_t'(op)),
        .res_o   (alu_res),
        .flags_o (alu_flags)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ext_d   = ext_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        mul_sum = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_t'(op) == OP_MUL) begin
                        state_d = ST_MUL_RUN;
                        mcand_d = operand;
                        ext_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        done_d = 1'b1;
                        if (op_t'(op) != OP_NOP) begin
                            acc_d   = alu_res;
                            flags_d = alu_flags;
                        end
                    end
                end
            end
            ST_MUL_RUN: begin
                // {cy, ext} = ext + (acc[0] ? mcand : 0), then {cy, ext, acc} >> 1.
                mul_sum = {1'b0, ext_q} + (acc_q[0] ? {1'b0, mcand_q} : '0);
                ext_d   = mul_sum[WIDTH:1];
                acc_d   = {mul_sum[0], acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    flags_d.n = ext_d[WIDTH-1];
                    flags_d.z = (ext_d == '0) && (acc_d == '0);
                    flags_d.c = (ext_d != '0);
                    flags_d.v = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ext_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            flags_q <= '{n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ext_q   <= ext_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == ST_MUL_RUN);
    assign done  = done_q;
    assign acc_o = acc_q;
    assign ext_o = ext_q;
    assign n     = flags_q.n;
    assign z     = flags_q.z;
    assign c     = flags_q.c;
    assign v     = flags_q.v;

endmodule

// File: tb/tb_acc_unit.sv
// Self-checking bench for acc_unit (WIDTH=8, NSRC=3) against an integer-arithmetic reference model.
module tb_acc_unit;

    localparam int W = 8;
    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NS*W-1:0] src_i = '0;
    logic [1:0]    src_sel = '0;
    logic [2:0]    op = '0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [W-1:0]  acc_o, ext_o;
    logic          n, z, c, v;

    int tests = 0;
    int fails = 0;

    int m_acc, m_ext;
    bit m_n, m_z, m_c, m_v;

    acc_unit #(.WIDTH(W), .NSRC(NS)) dut (
        .clk(clk), .rst(rst), .src_i(src_i), .src_sel(src_sel), .op(op),
        .start(start), .busy(busy), .done(done), .acc_o(acc_o), .ext_o(ext_o),
        .n(n), .z(z), .c(c), .v(v)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mvec();
        return {8'(m_acc), 8'(m_ext), m_n, m_z, m_c, m_v};
    endfunction

    task automatic model_reset();
        m_acc = 0; m_ext = 0; m_n = 0; m_z = 1; m_c = 0; m_v = 0;
    endtask

    task automatic model_op(input int opc, input int b);
        int a, r, s, sa, sb, p;
        a = m_acc;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r = a;
        case (opc)
            0: return;
            1: begin r = b; m_c = 0; m_v = 0; end
            2: begin s = a + b; r = s % 256; m_c = (s > 255); s = sa + sb; m_v = (s > 127) || (s < -128); end
            3: begin r = (a - b + 256) % 256; m_c = (a < b); s = sa - sb; m_v = (s > 127) || (s < -128); end
            4: begin r = a & b; m_c = 0; m_v = 0; end
            5: begin r = a | b; m_c = 0; m_v = 0; end
            6: begin r = a / 2; m_c = (a % 2) == 1; m_v = 0; end
            default: begin
                p = a * b;
                m_ext = p / 256; m_acc = p % 256;
                m_n = (m_ext >= 128); m_z = (p == 0); m_c = (m_ext != 0); m_v = 0;
                return;
            end
        endcase
        m_acc = r; m_n = (r >= 128); m_z = (r == 0);
    endtask

    // Drive one request and step past its accept edge; samples land 1ns after the edge.
    task automatic issue(input int opc, input int sel, input int val);
        for (int j = 0; j < NS; j++) src_i[j*W +: W] = 8'($urandom_range(1, 255));
        src_i[((sel < NS) ? sel : 0)*W +: W] = 8'(val);
        src_sel = 2'(sel);
        op = 3'(opc);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        tests++;
        if ({acc_o, ext_o, n, z, c, v, busy, done} !== {mvec(), 2'b00}) begin
            fails++;
            $display("FAIL reset: got %h required %h", {acc_o, ext_o, n, z, c, v, busy, done}, {mvec(), 2'b00});
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        issue(1, 1, 8'h80);
        model_op(1, 8'h80);
        tests++;
        if ({done, acc_o, n, z, c, v} !== {1'b1, 8'h80, 4'b1000}) begin
            fails++;
            $display("FAIL load_0x80: got %h required %h", {done, acc_o, n, z, c, v}, {1'b1, 8'h80, 4'b1000});
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_one_cycle: got %b required 0", done);
        end
    endtask

    task automatic test_add();
        issue(1, 0, 8'h7F); model_op(1, 8'h7F);
        issue(2, 2, 8'h01); model_op(2, 8'h01);
        tests++;
        if ({acc_o, n, z, c, v} !== {8'h80, 4'b1001} || {acc_o, ext_o, n, z, c, v} !== mvec()) begin
            fails++;
            $display("FAIL add_overflow: got %h required %h", {acc_o, n, z, c, v}, {8'h80, 4'b1001});
        end
        issue(2, 1, 8'h80); model_op(2, 8'h80);
        tests++;
        if ({acc_o, n, z, c, v} !== {8'h00, 4'b0111}) begin
            fails++;
            $display("FAIL add_carry_zero: got %h required %h", {acc_o, n, z, c, v}, {8'h00, 4'b0111});
        end
    endtask

    task automatic test_sub_shr();
        issue(1, 0, 8'h05); model_op(1, 8'h05);
        issue(3, 1, 8'h06); model_op(3, 8'h06);
        tests++;
        if ({acc_o, n, z, c, v} !== {8'hFF, 4'b1010}) begin
            fails++;
            $display("FAIL sub_borrow: got %h required %h", {acc_o, n, z, c, v}, {8'hFF, 4'b1010});
        end
        issue(6, 2, 8'h00); model_op(6, 0);
        tests++;
        if ({acc_o, n, z, c, v} !== {8'h7F, 4'b0010}) begin
            fails++;
            $display("FAIL shr: got %h required %h", {acc_o, n, z, c, v}, {8'h7F, 4'b0010});
        end
    endtask

    task automatic test_mul();
        int cyc, busy_cycles;
        issue(1, 0, 8'hFF); model_op(1, 8'hFF);
        issue(7, 2, 8'hFF); model_op(7, 8'hFF);
        cyc = 0; busy_cycles = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cycles++;
            // A LOAD request mid-multiply must be dropped.
            if (cyc == 2) begin op = 3'd1; src_i[W-1:0] = 8'h11; src_sel = 2'd0; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        tests++;
        if (cyc != 8 || busy_cycles != 8 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mul_latency: got cyc=%0d busy_cycles=%0d busy=%b required 8 8 0", cyc, busy_cycles, busy);
        end
        tests++;
        if ({ext_o, acc_o} !== 16'hFE01 || {acc_o, ext_o, n, z, c, v} !== mvec()) begin
            fails++;
            $display("FAIL mul_product: got %h required %h", {acc_o, ext_o, n, z, c, v}, mvec());
        end
        @(posedge clk);
        #1;
        tests++;
        if ({done, acc_o, ext_o} !== {1'b0, 8'h01, 8'hFE}) begin
            fails++;
            $display("FAIL mul_start_ignored: got %h required %h", {done, acc_o, ext_o}, {1'b0, 8'h01, 8'hFE});
        end
    endtask

    task automatic test_mul_reset();
        int seen_done;
        issue(1, 1, 8'h37); model_op(1, 8'h37);
        issue(7, 0, 8'h5A);
        seen_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tests++;
        if ({acc_o, ext_o, n, z, c, v, busy, done} !== {mvec(), 2'b00}) begin
            fails++;
            $display("FAIL mul_abort: got %h required %h", {acc_o, ext_o, n, z, c, v, busy, done}, {mvec(), 2'b00});
        end
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        tests++;
        if (seen_done != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mul_abort_no_done: got done_count=%0d busy=%b required 0 0", seen_done, busy);
        end
    endtask

    task automatic test_sel_nop();
        issue(1, 1, 8'h9C); model_op(1, 8'h9C);
        issue(1, 3, 8'h00); model_op(1, 0);
        tests++;
        if ({acc_o, n, z, c, v} !== {8'h00, 4'b0100}) begin
            fails++;
            $display("FAIL sel_out_of_range: got %h required %h", {acc_o, n, z, c, v}, {8'h00, 4'b0100});
        end
        issue(2, 2, 8'hC3); model_op(2, 8'hC3);
        issue(0, 1, 8'h42); model_op(0, 8'h42);
        tests++;
        if ({done, acc_o, ext_o, n, z, c, v} !== {1'b1, mvec()}) begin
            fails++;
            $display("FAIL nop: got %h required %h", {done, acc_o, ext_o, n, z, c, v}, {1'b1, mvec()});
        end
    endtask

    task automatic test_random();
        int opc, sel, val, cyc;
        for (int i = 0; i < 80; i++) begin
            opc = $urandom_range(0, 7);
            sel = $urandom_range(0, 3);
            val = $urandom_range(0, 255);
            if (($urandom_range(0, 7)) == 0) val = (($urandom_range(0, 1)) == 1) ? 255 : 0;
            issue(opc, sel, val);
            model_op(opc, val);
            if (opc == 7) begin
                wait_done(cyc);
                tests++;
                if (cyc != 8) begin
                    fails++;
                    $display("FAIL rand_mul_latency[%0d]: got %0d required 8", i, cyc);
                end
            end
            tests++;
            if ({done, acc_o, ext_o, n, z, c, v} !== {1'b1, mvec()}) begin
                fails++;
                $display("FAIL rand_op%0d[%0d]: got %h required %h", opc, i, {done, acc_o, ext_o, n, z, c, v}, {1'b1, mvec()});
            end
        end
    endtask

    task automatic test_back_to_back();
        int opc, val;
        for (int i = 0; i < 12; i++) begin
            opc = $urandom_range(0, 6);
            val = $urandom_range(0, 255);
            issue(opc, i % 3, val);
            model_op(opc, val);
            tests++;
            if ({done, busy, acc_o, ext_o, n, z, c, v} !== {2'b10, mvec()}) begin
                fails++;
                $display("FAIL b2b[%0d]: got %h required %h", i, {done, busy, acc_o, ext_o, n, z, c, v}, {2'b10, mvec()});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load();
        test_add();
        test_sub_shr();
        test_mul();
        test_mul_reset();
        test_sel_nop();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
